// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types and defaults: state encoding seen on state_o and
// count-bus defaults shared with counterCtrl/bcdCtrl.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LAP   = 2'd2,
        ST_PAUSE = 2'd3
    } state_e;

    localparam int CNT_W_DEF   = 7;
    localparam int CNT_MAX_DEF = 99;

    function automatic logic is_running(input state_e s);
        return (s == ST_RUN) || (s == ST_LAP);
    endfunction

endpackage

// File: rtl/stopwatch_run_ctrl_debounce.sv
// Button conditioner: 2-FF synchroniser, stable-sample counter and a
// single-cycle pulse on each debounced rising edge.
module btn_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_i,
    output logic press_o
);

    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic           sync1_q, sync2_q;
    logic           level_q, level_prev_q, press_q;
    logic [DBW-1:0] stable_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
            stable_q     <= '0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            level_prev_q <= level_q;
            press_q      <= level_q & ~level_prev_q;
            // level flips only after DB_CYCLES consecutive samples disagree with it
            if (sync2_q == level_q) begin
                stable_q <= '0;
            end else if (stable_q == DBW'(DB_CYCLES - 1)) begin
                level_q  <= sync2_q;
                stable_q <= '0;
            end else begin
                stable_q <= stable_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/stopwatch_run_ctrl.sv
// Run/lap/reset sequencer: debounced buttons drive the IDLE/RUN/LAP/PAUSE
// FSM, the count-tick prescaler, the counter clear pulse and the lap freeze.
module stopwatch_run_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int CNT_MAX   = CNT_MAX_DEF,
    parameter int TICK_DIV  = 10_000_000,
    parameter int DB_CYCLES = 1_000_000,
    parameter int AUTO_STOP = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             btn_ss,
    input  logic             btn_lap,
    input  logic [CNT_W-1:0] cnt_in,
    output logic             cnt_tick,
    output logic             cnt_clr,
    output logic             run,
    output logic             lap_active,
    output logic [CNT_W-1:0] disp_cnt,
    output logic [1:0]       state_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic ss_press, lap_press;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
        .clk    (clk),
        .clr    (clr),
        .btn_i  (btn_ss),
        .press_o(ss_press)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
        .clk    (clk),
        .clr    (clr),
        .btn_i  (btn_lap),
        .press_o(lap_press)
    );

    state_e           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] lap_q, lap_d;
    logic             tick_q, tick_d;
    logic             cclr_q, cclr_d;
    logic             run_q, lap_active_q;
    logic             at_terminal;

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        lap_d       = lap_q;
        tick_d      = 1'b0;
        cclr_d      = 1'b0;
        at_terminal = 1'b0;
        case (state_q)
            ST_IDLE: begin
                presc_d = '0;
                if (ss_press) state_d = ST_RUN;
            end
            ST_RUN, ST_LAP: begin
                if (presc_q == PW'(TICK_DIV - 1)) begin
                    presc_d = '0;
                    if ((AUTO_STOP != 0) && (cnt_in == CNT_W'(CNT_MAX))) begin
                        at_terminal = 1'b1;
                        state_d     = ST_PAUSE;
                    end else begin
                        tick_d = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
                // terminal-count pause overrides any press on the same cycle; ss beats lap
                if (!at_terminal) begin
                    if (ss_press) begin
                        state_d = ST_PAUSE;
                    end else if (lap_press) begin
                        if (state_q == ST_RUN) begin
                            state_d = ST_LAP;
                            lap_d   = cnt_in;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
            end
            ST_PAUSE: begin
                if (ss_press) begin
                    state_d = ST_RUN;
                end else if (lap_press) begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                    cclr_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            lap_q        <= '0;
            tick_q       <= 1'b0;
            cclr_q       <= 1'b0;
            run_q        <= 1'b0;
            lap_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            lap_q        <= lap_d;
            tick_q       <= tick_d;
            cclr_q       <= cclr_d;
            run_q        <= is_running(state_d);
            lap_active_q <= (state_d == ST_LAP);
        end
    end

    assign cnt_tick   = tick_q;
    assign cnt_clr    = cclr_q;
    assign run        = run_q;
    assign lap_active = lap_active_q;
    assign state_o    = state_q;
    assign disp_cnt   = lap_active_q ? lap_q : cnt_in;

endmodule

// File: tb/tb_stopwatch_run_ctrl.sv
// Bench for stopwatch_run_ctrl: transition table, directed corner sequences
// and a randomized phase, all scored against a cycle-level behavioural model.
module tb_stopwatch_run_ctrl;

    localparam int DB = 4;
    localparam int TD = 5;
    localparam int CW = 7;
    localparam int CM = 99;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          btn_ss = 1'b0, btn_lap = 1'b0;
    logic [CW-1:0] cnt_a = '0, cnt_b = '0;
    logic          tick_a, cclr_a, run_a, lap_a;
    logic [CW-1:0] disp_a;
    logic [1:0]    st_a;
    logic          tick_b, cclr_b, run_b, lap_b;
    logic [CW-1:0] disp_b;
    logic [1:0]    st_b;

    logic          preset_req = 1'b0;
    logic [CW-1:0] preset_val = '0;

    int n_checks = 0;
    int n_fail   = 0;
    logic sb_en  = 1'b0;

    always #5 clk = ~clk;

    stopwatch_run_ctrl #(.CNT_W(CW), .CNT_MAX(CM), .TICK_DIV(TD), .DB_CYCLES(DB), .AUTO_STOP(1)) dut (
        .clk(clk), .clr(clr), .btn_ss(btn_ss), .btn_lap(btn_lap), .cnt_in(cnt_a),
        .cnt_tick(tick_a), .cnt_clr(cclr_a), .run(run_a), .lap_active(lap_a),
        .disp_cnt(disp_a), .state_o(st_a)
    );

    stopwatch_run_ctrl #(.CNT_W(CW), .CNT_MAX(CM), .TICK_DIV(TD), .DB_CYCLES(DB), .AUTO_STOP(0)) dut_ns (
        .clk(clk), .clr(clr), .btn_ss(btn_ss), .btn_lap(btn_lap), .cnt_in(cnt_b),
        .cnt_tick(tick_b), .cnt_clr(cclr_b), .run(run_b), .lap_active(lap_b),
        .disp_cnt(disp_b), .state_o(st_b)
    );

    // External counter units fed by each DUT; preset lets the bench place the count.
    always @(posedge clk) begin
        if (clr || cclr_a)   cnt_a <= '0;
        else if (preset_req) cnt_a <= preset_val;
        else if (tick_a)     cnt_a <= (cnt_a == CW'(CM)) ? '0 : cnt_a + 7'd1;
        if (clr || cclr_b)   cnt_b <= '0;
        else if (preset_req) cnt_b <= preset_val;
        else if (tick_b)     cnt_b <= (cnt_b == CW'(CM)) ? '0 : cnt_b + 7'd1;
    end

    // Behavioural model: raw-sample history decides debounced levels; presses act two cycles later.
    logic [DB+1:0] m_hs = '0, m_hl = '0;
    logic          m_lvl_s = 0, m_lvl_l = 0, m_rise_s = 0, m_rise_l = 0, m_p_s = 0, m_p_l = 0;
    int            m_state = 0, m_acc = 0;
    logic [CW-1:0] m_lap = '0;
    logic          m_tick = 0, m_cclr = 0;

    function automatic logic flips(input logic [DB+1:0] h, input logic lvl);
        return h[DB+1:2] == {DB{~lvl}};
    endfunction

    always @(posedge clk) begin
        logic ss, lp, stop;
        if (clr) begin
            m_hs = '0; m_hl = '0; m_lvl_s = 0; m_lvl_l = 0; m_rise_s = 0; m_rise_l = 0;
            m_p_s = 0; m_p_l = 0; m_state = 0; m_acc = 0; m_lap = '0; m_tick = 0; m_cclr = 0;
        end else begin
            ss = m_p_s; lp = m_p_l; stop = 0;
            m_tick = 0; m_cclr = 0;
            if (m_state == 1 || m_state == 2) begin
                if (m_acc + 1 == TD) begin
                    m_acc = 0;
                    if (cnt_a == CW'(CM)) begin m_state = 3; stop = 1; end
                    else m_tick = 1;
                end else m_acc++;
                if (!stop) begin
                    if (ss) m_state = 3;
                    else if (lp) begin
                        if (m_state == 1) begin m_state = 2; m_lap = cnt_a; end
                        else m_state = 1;
                    end
                end
            end else if (m_state == 0) begin
                m_acc = 0;
                if (ss) m_state = 1;
            end else begin
                if (ss) m_state = 1;
                else if (lp) begin m_state = 0; m_cclr = 1; m_acc = 0; end
            end
            m_p_s = m_rise_s; m_p_l = m_rise_l;
            m_hs = {m_hs[DB:0], btn_ss};
            m_hl = {m_hl[DB:0], btn_lap};
            m_rise_s = 0; m_rise_l = 0;
            if (flips(m_hs, m_lvl_s)) begin m_lvl_s = ~m_lvl_s; m_rise_s = m_lvl_s; end
            if (flips(m_hl, m_lvl_l)) begin m_lvl_l = ~m_lvl_l; m_rise_l = m_lvl_l; end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic step();
        logic          e_run, e_lap;
        logic [CW-1:0] e_disp;
        @(negedge clk);
        if (sb_en) begin
            e_run  = (m_state == 1 || m_state == 2);
            e_lap  = (m_state == 2);
            e_disp = e_lap ? m_lap : cnt_a;
            n_checks++;
            if (int'(st_a) != m_state || run_a !== e_run || lap_a !== e_lap ||
                tick_a !== m_tick || cclr_a !== m_cclr || disp_a !== e_disp) begin
                n_fail++;
                $display("FAIL scoreboard @%0t: got st=%0d run=%b lap=%b tick=%b clr=%b disp=%0d, expected st=%0d run=%b lap=%b tick=%b clr=%b disp=%0d",
                         $time, st_a, run_a, lap_a, tick_a, cclr_a, disp_a,
                         m_state, e_run, e_lap, m_tick, m_cclr, e_disp);
            end
        end
    endtask

    task automatic press(input logic s, input logic l);
        btn_ss = s; btn_lap = l;
        repeat (DB + 4) step();
        btn_ss = 0; btn_lap = 0;
        repeat (DB + 4) step();
    endtask

    task automatic do_reset();
        clr = 1; step(); step(); clr = 0;
    endtask

    task automatic wait_tick();
        int n = 0;
        step();
        while (tick_a !== 1'b1 && n < 20) begin step(); n++; end
        chk("wait_tick_bound", int'(n < 20), 1);
    endtask

    typedef struct {
        logic       ss;
        logic       lap;
        logic [1:0] st;
        logic       run;
        logic       lapact;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int first_run, t1, t2, n, cclr_cnt, rise_step;
        logic seen_run;

        tbl[0]  = '{0, 1, 2'd0, 0, 0};
        tbl[1]  = '{1, 0, 2'd1, 1, 0};
        tbl[2]  = '{0, 1, 2'd2, 1, 1};
        tbl[3]  = '{0, 1, 2'd1, 1, 0};
        tbl[4]  = '{1, 1, 2'd3, 0, 0};
        tbl[5]  = '{1, 0, 2'd1, 1, 0};
        tbl[6]  = '{0, 1, 2'd2, 1, 1};
        tbl[7]  = '{1, 1, 2'd3, 0, 0};
        tbl[8]  = '{0, 1, 2'd0, 0, 0};
        tbl[9]  = '{1, 1, 2'd1, 1, 0};
        tbl[10] = '{0, 1, 2'd2, 1, 1};
        tbl[11] = '{1, 0, 2'd3, 0, 0};
        tbl[12] = '{1, 0, 2'd1, 1, 0};

        // Reset state
        step();
        sb_en = 1;
        chk("reset_state", int'(st_a), 0);
        chk("reset_run", int'(run_a), 0);
        chk("reset_lap", int'(lap_a), 0);
        chk("reset_tick", int'(tick_a), 0);
        chk("reset_cclr", int'(cclr_a), 0);
        chk("reset_disp", int'(disp_a), 0);
        step(); clr = 0;

        // 1: hold ss; run rises DB+4 cycles after the button, ticks every TD, no repeat
        btn_ss = 1; first_run = 0; t1 = 0; t2 = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (run_a === 1'b1 && first_run == 0) first_run = i;
            if (tick_a === 1'b1) begin
                if (t1 == 0) t1 = i; else if (t2 == 0) t2 = i;
            end
        end
        btn_ss = 0;
        chk("run_rise_latency", first_run, DB + 4);
        chk("first_tick", t1, DB + 4 + TD);
        chk("second_tick", t2, DB + 4 + 2 * TD);
        repeat (DB + 4) step();
        chk("held_no_repeat", int'(st_a), 1);

        // 2: bounce shorter than the debounce window, then exact boundary lengths
        do_reset();
        seen_run = 0;
        for (int i = 0; i < 8; i++) begin
            btn_ss = ((i / 2) % 2) == 0;
            step();
            if (run_a === 1'b1) seen_run = 1;
        end
        btn_ss = 0;
        repeat (12) begin step(); if (run_a === 1'b1) seen_run = 1; end
        chk("bounce_no_run", int'(seen_run), 0);
        chk("bounce_idle", int'(st_a), 0);
        btn_ss = 1; repeat (DB - 1) step(); btn_ss = 0;
        repeat (DB + 8) step();
        chk("short_press_ignored", int'(st_a), 0);
        btn_ss = 1; repeat (DB) step(); btn_ss = 0;
        repeat (DB + 8) step();
        chk("exact_press_accepted", int'(st_a), 1);

        // Transition table from IDLE
        do_reset();
        for (int i = 0; i < 13; i++) begin
            press(tbl[i].ss, tbl[i].lap);
            chk($sformatf("tbl%0d_state", i), int'(st_a), int'(tbl[i].st));
            chk($sformatf("tbl%0d_run", i), int'(run_a), int'(tbl[i].run));
            chk($sformatf("tbl%0d_lap", i), int'(lap_a), int'(tbl[i].lapact));
        end

        // 3: lap freezes 37 while counter advances, second lap returns to live
        btn_lap = 1;
        repeat (DB + 2) step();
        preset_val = 7'd37; preset_req = 1; step(); preset_req = 0;
        step();
        chk("lap_latch_active", int'(lap_a), 1);
        chk("lap_latch_disp", int'(disp_a), 37);
        btn_lap = 0;
        n = 0;
        while (cnt_a != 7'd42 && n < 60) begin step(); n++; end
        chk("count_reach_42", int'(cnt_a), 42);
        chk("lap_frozen_disp", int'(disp_a), 37);
        chk("lap_frozen_active", int'(lap_a), 1);
        press(0, 1);
        chk("lap_release_state", int'(st_a), 1);
        chk("lap_release_live", int'(disp_a), int'(cnt_a));

        // 4: pause two cycles into a period, resume finishes the remaining three
        wait_tick();
        repeat (TD - 1) step();
        btn_ss = 1;
        repeat (DB + 4) step();
        btn_ss = 0;
        chk("pause_state", int'(st_a), 3);
        n = 0;
        repeat (20) begin step(); if (tick_a === 1'b1) n++; end
        chk("pause_no_ticks", n, 0);
        btn_ss = 1; n = 0;
        while (run_a !== 1'b1 && n < 20) begin step(); n++; end
        rise_step = 0;
        step();
        while (tick_a !== 1'b1 && rise_step < 20) begin step(); rise_step++; end
        btn_ss = 0;
        chk("resume_tick_delay", rise_step + 1, 3);
        repeat (DB + 4) step();

        // 5: PAUSE + lap clears once; simultaneous presses favour ss
        press(1, 0);
        chk("pre_clear_pause", int'(st_a), 3);
        btn_lap = 1; cclr_cnt = 0;
        for (int i = 0; i < 2 * (DB + 4); i++) begin
            if (i == DB + 4) btn_lap = 0;
            step();
            if (cclr_a === 1'b1) cclr_cnt++;
        end
        chk("cclr_single_pulse", cclr_cnt, 1);
        chk("clear_to_idle", int'(st_a), 0);
        chk("counter_cleared", int'(cnt_a), 0);
        press(1, 1);
        chk("both_press_run", int'(st_a), 1);
        chk("both_press_no_lap", int'(lap_a), 0);

        // 6: terminal count in LAP, with and without auto-stop
        press(0, 1);
        chk("pre_term_lap", int'(st_a), 2);
        wait_tick();
        preset_val = CW'(CM); preset_req = 1; step(); preset_req = 0;
        repeat (TD - 2) step();
        chk("pre_term_no_tick", int'(tick_a), 0);
        step();
        chk("term_tick_suppressed", int'(tick_a), 0);
        chk("term_state_pause", int'(st_a), 3);
        chk("term_run_low", int'(run_a), 0);
        chk("term_lap_cleared", int'(lap_a), 0);
        chk("term_disp_live", int'(disp_a), CM);
        chk("noauto_tick", int'(tick_b), 1);
        step();
        chk("noauto_wrap", int'(cnt_b), 0);
        chk("noauto_running", int'(run_b), 1);
        chk("noauto_state_lap", int'(st_b), 2);
        chk("noauto_lap_active", int'(lap_b), 1);
        chk("noauto_disp_frozen", int'(disp_b), int'(m_lap));

        // clr mid-operation: straight to IDLE with no clear pulse
        clr = 1; step(); clr = 0;
        chk("midclr_idle", int'(st_a), 0);
        chk("midclr_no_cclr", int'(cclr_a), 0);

        // Randomized phase
        do_reset();
        repeat (200) begin
            if ($urandom_range(0, 29) == 0) begin clr = 1; step(); clr = 0; end
            if ($urandom_range(0, 7) == 0) begin
                preset_val = CW'($urandom_range(90, 99)); preset_req = 1; step(); preset_req = 0;
            end
            btn_ss  = ($urandom_range(0, 3) == 0);
            btn_lap = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(1, 12)) step();
        end
        btn_ss = 0; btn_lap = 0;
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
